build_info_reader: RTL and testbench

//  Consumer of the build-identity sources: the 64b git hash and the USR_ACCESS word (bitgen timestamp).

---
 rtl/build_info_reader_if.sv | 21 ++
 rtl/build_info_reader.sv | 173 +++++++++++++++++
 tb/tb_build_info_reader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/build_info_reader_if.sv
// Register read port between the PS/debug master and build_info_reader.
interface build_info_reader_if;
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/build_info_reader.sv
// build_info_reader: captures the git hash and a stable USR_ACCESS word once,
// decodes the bitgen timestamp and serves everything through a 1-cycle read port.
// Optional feature macro: BUILD_INFO_DECODE_EN (timestamp decode, addrs 4/5, date_err).
module build_info_reader #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [31:0] MAGIC         = 32'h42494E46
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         hash_i,
    input  logic [31:0]         usr_data_i,
    input  logic                usr_valid_i,
    build_info_reader_if.slave  rd,
    output logic                info_valid_o
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CNT_W1 = CNT_W + 1;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_STAB = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   vld_s;
    logic [31:0]            sample_q, sample_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W1-1:0]      cnt_inc;
    logic                   capture;
    logic [31:0]            raw_q;
    logic [63:0]            hash_q;
    logic                   info_valid_q;
    logic                   rd_ack_q;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   date_err;
    logic [31:0]            date_word;
    logic [31:0]            time_word;

    // DATAVALID is asynchronous to clk: plain flop-chain synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], usr_valid_i};
        end
    end

    assign vld_s   = sync_q[SYNC_STAGES-1];
    assign cnt_inc = {1'b0, cnt_q} + CNT_W1'(1);

    // Capture FSM next-state: wait for valid, require a run of identical samples, then lock
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                if (vld_s) begin
                    state_d  = S_STAB;
                    sample_d = usr_data_i;
                    cnt_d    = CNT_W'(1);
                end
            end
            S_STAB: begin
                if (!vld_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (usr_data_i == sample_q) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    if (cnt_inc >= CNT_W1'(STABLE_CYCLES)) begin
                        state_d = S_DONE;
                        capture = 1'b1;
                    end
                end else begin
                    sample_d = usr_data_i;
                    cnt_d    = CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Capture state and captured identity registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT;
            sample_q     <= '0;
            cnt_q        <= '0;
            raw_q        <= '0;
            hash_q       <= '0;
            info_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            cnt_q        <= cnt_d;
            info_valid_q <= (state_d == S_DONE);
            if (capture) begin
                raw_q  <= sample_q;
                hash_q <= hash_i;
            end
        end
    end

`ifdef BUILD_INFO_DECODE_EN
    logic [4:0]  dec_day;
    logic [3:0]  dec_month;
    logic [15:0] dec_year;
    logic [4:0]  dec_hour;
    logic [5:0]  dec_min;
    logic [5:0]  dec_sec;

    assign dec_day   = raw_q[31:27];
    assign dec_month = raw_q[26:23];
    assign dec_year  = 16'd2000 + 16'(raw_q[22:17]);
    assign dec_hour  = raw_q[16:12];
    assign dec_min   = raw_q[11:6];
    assign dec_sec   = raw_q[5:0];

    // Out-of-range fields are flagged but still reported as-is
    assign date_err  = (state_q == S_DONE) &&
                       ((dec_month == 4'd0) || (dec_month > 4'd12) || (dec_day == 5'd0) ||
                        (dec_hour > 5'd23) || (dec_min > 6'd59) || (dec_sec > 6'd59));
    assign date_word = {dec_year, 4'h0, dec_month, 3'h0, dec_day};
    assign time_word = {11'h0, dec_hour, 2'h0, dec_min, 2'h0, dec_sec};
`else
    assign date_err  = 1'b0;
    assign date_word = 32'h0;
    assign time_word = 32'h0;
`endif

    // Read mux; captured values are masked until capture completes, data holds between acks
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd.rd_req) begin
            unique case (rd.rd_addr)
                3'd0:    rd_data_d = info_valid_q ? hash_q[31:0]  : 32'h0;
                3'd1:    rd_data_d = info_valid_q ? hash_q[63:32] : 32'h0;
                3'd2:    rd_data_d = info_valid_q ? raw_q         : 32'h0;
                3'd3:    rd_data_d = {24'h0, date_err, 3'b0, state_q, 1'b0, info_valid_q};
                3'd4:    rd_data_d = info_valid_q ? date_word     : 32'h0;
                3'd5:    rd_data_d = info_valid_q ? time_word     : 32'h0;
                3'd6:    rd_data_d = MAGIC;
                default: rd_data_d = 32'h0;
            endcase
        end
    end

    // Read port registers: ack one cycle after each request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q  <= rd.rd_req;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd.rd_ack    = rd_ack_q;
    assign rd.rd_data   = rd_data_q;
    assign info_valid_o = info_valid_q;

endmodule

// File: tb/tb_build_info_reader.sv
// Self-checking bench for build_info_reader: read-port scoreboard plus capture sequences.
`timescale 1ns/1ps
module tb_build_info_reader;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned STABLE_CYCLES = 4;
    localparam logic [31:0] MAGIC         = 32'h42494E46;

`ifdef BUILD_INFO_DECODE_EN
    localparam logic [31:0] EXP_DATE    = 32'h07E8060F;
    localparam logic [31:0] EXP_TIME    = 32'h000D2D1E;
    localparam logic [31:0] EXP_DATE_FF = 32'h080F0F1F;
    localparam logic [31:0] EXP_TIME_FF = 32'h001F3F3F;
    localparam logic [31:0] ERR_BIT     = 32'h80;
`else
    localparam logic [31:0] EXP_DATE    = 32'h0;
    localparam logic [31:0] EXP_TIME    = 32'h0;
    localparam logic [31:0] EXP_DATE_FF = 32'h0;
    localparam logic [31:0] EXP_TIME_FF = 32'h0;
    localparam logic [31:0] ERR_BIT     = 32'h0;
`endif

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] hash;
    logic [31:0] usr_set;
    logic [31:0] tog_data;
    logic [31:0] usr_data;
    logic        usr_valid;
    logic        info_valid;
    int          tog_per = 0;

    int checks = 0;
    int errors = 0;

    vec_t exp_q[$];
    vec_t tbl_pre[8];
    vec_t tbl_post[8];

    build_info_reader_if rd_bus();

    build_info_reader #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAGIC        (MAGIC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hash_i      (hash),
        .usr_data_i  (usr_data),
        .usr_valid_i (usr_valid),
        .rd          (rd_bus),
        .info_valid_o(info_valid)
    );

    always #5 clk = ~clk;

    assign usr_data = (tog_per != 0) ? tog_data : usr_set;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Request seen by the DUT on the previous edge; the ack must follow it exactly
    logic req_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) req_prev <= 1'b0;
        else     req_prev <= rd_bus.rd_req;
    end

    // Read-port monitor: ack timing, scoreboard pop/compare, hold between acks
    initial begin
        vec_t        v;
        logic [31:0] last_exp;
        last_exp = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_exp = 32'h0;
            end else begin
                check("ack_timing", 32'(rd_bus.rd_ack), 32'(req_prev));
                if (rd_bus.rd_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: data 0x%08h with empty scoreboard", rd_bus.rd_data);
                    end else begin
                        v = exp_q.pop_front();
                        check($sformatf("rd_addr%0d", v.addr), rd_bus.rd_data, v.data);
                        last_exp = v.data;
                    end
                end else begin
                    check("rd_hold", rd_bus.rd_data, last_exp);
                end
            end
        end
    end

    // Background data changer for the unstable-USR_ACCESS sequences
    initial begin
        int k;
        k = 0;
        tog_data = 32'h1234_0000;
        forever begin
            @(posedge clk);
            #1;
            if (tog_per != 0) begin
                k++;
                if (k >= tog_per) begin
                    k = 0;
                    tog_data = tog_data + 32'h0101_0101;
                end
            end else begin
                k = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic issue(input logic [2:0] a, input logic [31:0] e);
        vec_t v;
        v.addr = a;
        v.data = e;
        exp_q.push_back(v);
        rd_bus.rd_req  = 1'b1;
        rd_bus.rd_addr = a;
        @(posedge clk);
        #1;
        rd_bus.rd_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string name, output int cycles);
        cycles = 0;
        while (!info_valid && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check(name, 32'(info_valid), 32'h1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        usr_valid = 1'b0;
        tog_per   = 0;
        rd_bus.rd_req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ack",   32'(rd_bus.rd_ack), 32'h0);
        check("rst_data",  rd_bus.rd_data,     32'h0);
        check("rst_valid", 32'(info_valid),    32'h0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        int lat;

        tbl_pre[0] = '{3'd0, 32'h0};
        tbl_pre[1] = '{3'd1, 32'h0};
        tbl_pre[2] = '{3'd2, 32'h0};
        tbl_pre[3] = '{3'd3, 32'h0};
        tbl_pre[4] = '{3'd4, 32'h0};
        tbl_pre[5] = '{3'd5, 32'h0};
        tbl_pre[6] = '{3'd6, MAGIC};
        tbl_pre[7] = '{3'd7, 32'h0};

        tbl_post[0] = '{3'd0, 32'h89ABCDEF};
        tbl_post[1] = '{3'd1, 32'h01234567};
        tbl_post[2] = '{3'd2, 32'h7B30DB5E};
        tbl_post[3] = '{3'd3, 32'h09};
        tbl_post[4] = '{3'd4, EXP_DATE};
        tbl_post[5] = '{3'd5, EXP_TIME};
        tbl_post[6] = '{3'd6, MAGIC};
        tbl_post[7] = '{3'd7, 32'h0};

        hash           = 64'h0123456789ABCDEF;
        usr_set        = 32'h7B30DB5E;
        usr_valid      = 1'b0;
        rd_bus.rd_req  = 1'b0;
        rd_bus.rd_addr = 3'd0;

        // Reset held with a request pending: no ack, outputs stay 0
        repeat (2) @(posedge clk);
        #1;
        rd_bus.rd_req  = 1'b1;
        rd_bus.rd_addr = 3'd6;
        repeat (2) @(posedge clk);
        #1;
        check("in_rst_ack",  32'(rd_bus.rd_ack), 32'h0);
        check("in_rst_data", rd_bus.rd_data,     32'h0);
        rd_bus.rd_req = 1'b0;
        do_reset();

        // Pre-capture register map
        for (int i = 0; i < 8; i++) begin
            issue(tbl_pre[i].addr, tbl_pre[i].data);
            @(posedge clk);
            #1;
        end
        drain();

        // Capture with an async-phase valid edge
        @(posedge clk);
        #3;
        usr_valid = 1'b1;
        wait_valid("capture_normal", lat);
        checks++;
        if (lat < int'(SYNC_STAGES + STABLE_CYCLES) - 1 || lat > int'(SYNC_STAGES + STABLE_CYCLES) + 1) begin
            errors++;
            $display("FAIL capture_latency: got %0d cycles expected %0d +/-1", lat, SYNC_STAGES + STABLE_CYCLES);
        end

        // Post-capture register map, spaced reads
        for (int i = 0; i < 8; i++) begin
            issue(tbl_post[i].addr, tbl_post[i].data);
            @(posedge clk);
            #1;
        end
        drain();

        // Same map back-to-back, one request every cycle
        for (int i = 0; i < 8; i++) begin
            issue(tbl_post[i].addr, tbl_post[i].data);
        end
        drain();

        // Later valid changes are ignored once captured
        usr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("done_sticky", 32'(info_valid), 32'h1);
        issue(3'd3, 32'h09);
        drain();

        // Data changing every 2 cycles never settles; then a held all-ones word captures
        do_reset();
        tog_per   = 2;
        usr_valid = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("toggle_no_capture", 32'(info_valid), 32'h0);
        issue(3'd3, 32'h04);
        issue(3'd2, 32'h0);
        drain();
        usr_set = 32'hFFFFFFFF;
        tog_per = 0;
        wait_valid("capture_ones", lat);
        issue(3'd3, 32'h09 | ERR_BIT);
        issue(3'd2, 32'hFFFFFFFF);
        issue(3'd4, EXP_DATE_FF);
        issue(3'd5, EXP_TIME_FF);
        drain();

        // Valid drop during STAB returns to WAIT
        do_reset();
        tog_per   = 1;
        usr_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(3'd3, 32'h04);
        drain();
        usr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(3'd3, 32'h00);
        drain();

        // Reset in the middle of STAB aborts the capture
        usr_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        issue(3'd3, 32'h04);
        drain();
        usr_valid = 1'b0;
        do_reset();
        issue(3'd3, 32'h00);
        drain();

        // Recapture; a read sampled on the DONE edge still sees the pre-capture 0
        usr_set = 32'h7B30DB5E;
        tog_per = 0;
        @(posedge clk);
        #3;
        usr_valid = 1'b1;
        repeat (SYNC_STAGES + STABLE_CYCLES - 1) @(posedge clk);
        #1;
        check("pre_done_edge_valid", 32'(info_valid), 32'h0);
        issue(3'd2, 32'h0);
        check("recapture_valid", 32'(info_valid), 32'h1);
        issue(3'd2, 32'h7B30DB5E);
        issue(3'd0, 32'h89ABCDEF);
        issue(3'd3, 32'h09);
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
